// File: rtl/gig_ethernet_pcs_pma_reset_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gig_ethernet_pcs_pma_reset_pkg
// Purpose  : Shared types and elaboration-time helpers for the PCS/PMA reset
//            synchroniser and sequencer.
// Contents : state_e  - sequencer FSM states
//            max_f    - larger of two integers
//            clog2_f  - ceiling log2, usable in localparam expressions
// Revision : 1.0 - initial release
// ============================================================================
package gig_ethernet_pcs_pma_reset_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gig_ethernet_pcs_pma_sync_bit.sv
`default_nettype none
// ============================================================================
// Module   : gig_ethernet_pcs_pma_sync_bit
// Purpose  : Single-bit multi-flop synchroniser for an asynchronous reset
//            request. Resets to 1 so a freshly reset block starts out
//            "requesting" and only releases once a clean 0 has propagated.
// Ports    : clk      in  1  destination clock
//            reset_n  in  1  synchronous active-low reset (chain -> all 1s)
//            d_i      in  1  asynchronous input
//            q_o      out 1  synchronised output (DEPTH edges of latency)
// Revision : 1.0 - initial release
// ============================================================================
module gig_ethernet_pcs_pma_sync_bit #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  // Keep the chain together in one slice and out of shift-register primitives
  // so the metastability resolution time is not eaten by routing.
  (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/gig_ethernet_pcs_pma_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : gig_ethernet_pcs_pma_reset_seq
// Purpose  : Synchronises and merges NUM_REQ asynchronous reset requests,
//            stretches the merged reset to at least HOLD_CYCLES, then
//            releases NUM_OUT resets in order, STAGGER_CYCLES apart.
// Ports    : clk         in  1        sole clock
//            reset_n     in  1        synchronous active-low block reset
//            reset_req   in  NUM_REQ  async reset requests, active-high
//            reset_out   out NUM_OUT  sequenced resets, bit 0 released first
//            reset_done  out 1        high once every reset_out is released
// Revision : 1.0 - initial release
// ============================================================================
module gig_ethernet_pcs_pma_reset_seq
  import gig_ethernet_pcs_pma_reset_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int SYNC_STAGES    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int NUM_OUT        = 3,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] reset_req,
  output logic [NUM_OUT-1:0] reset_out,
  output logic               reset_done
);

  localparam int CNT_W = max_f(clog2_f(max_f(HOLD_CYCLES, STAGGER_CYCLES) + 1), 1);
  localparam int IDX_W = max_f(clog2_f(NUM_OUT), 1);

  logic [NUM_REQ-1:0] req_sync;
  logic               any_req;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_OUT-1:0] reset_out_q;
  logic               reset_done_q;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sync
      gig_ethernet_pcs_pma_sync_bit #(
        .DEPTH (SYNC_STAGES)
      ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (reset_req[gi]),
        .q_o     (req_sync[gi])
      );
    end
  endgenerate

  assign any_req = |req_sync;

  // A request always wins over a counter expiry in the same cycle, so every
  // state tests any_req first. Re-assertion is all-at-once; released bits
  // are never set back individually.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_ASSERT;
      cnt_q        <= '0;
      idx_q        <= '0;
      reset_out_q  <= '1;
      reset_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          reset_out_q  <= '1;
          reset_done_q <= 1'b0;
          cnt_q        <= '0;
          idx_q        <= '0;
          if (!any_req) begin
            state_q <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (any_req) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt_q          <= '0;
            reset_out_q[0] <= 1'b0;
            if (NUM_OUT == 1) begin
              // Single output: nothing to stagger, finish immediately.
              state_q      <= ST_DONE;
              reset_done_q <= 1'b1;
            end else begin
              state_q <= ST_RELEASE;
              idx_q   <= IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (any_req) begin
            state_q      <= ST_ASSERT;
            reset_out_q  <= '1;
            reset_done_q <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
          end else if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
            cnt_q <= '0;
            // Loop form keeps the index in range for every NUM_OUT.
            for (int k = 0; k < NUM_OUT; k++) begin
              if (IDX_W'(k) == idx_q) reset_out_q[k] <= 1'b0;
            end
            if (idx_q == IDX_W'(NUM_OUT - 1)) begin
              state_q      <= ST_DONE;
              reset_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
          if (any_req) begin
            state_q      <= ST_ASSERT;
            reset_out_q  <= '1;
            reset_done_q <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
          end
        end

        default: begin
          state_q      <= ST_ASSERT;
          reset_out_q  <= '1;
          reset_done_q <= 1'b0;
          cnt_q        <= '0;
          idx_q        <= '0;
        end
      endcase
    end
  end

  assign reset_out  = reset_out_q;
  assign reset_done = reset_done_q;

endmodule
`default_nettype wire

// File: tb/tb_gig_ethernet_pcs_pma_reset_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gig_ethernet_pcs_pma_reset_seq
// Purpose  : Self-checking bench. DUT A uses default parameters, DUT B uses
//            NUM_OUT=1, HOLD_CYCLES=1, SYNC_STAGES=2. Each DUT is compared
//            every cycle against a run-length model: the outputs depend only
//            on how many consecutive edges the synchronised requests have
//            been idle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gig_ethernet_pcs_pma_reset_seq;

  localparam int A_S = 4, A_H = 16, A_N = 3, A_G = 8;
  localparam int B_S = 2, B_H = 1,  B_N = 1, B_G = 8;

  logic       clk = 1'b0;
  logic       rstn_a = 1'b0, rstn_b = 1'b0;
  logic [1:0] req_a = 2'b00, req_b = 2'b00;
  logic [2:0] out_a;
  logic [0:0] out_b;
  logic       done_a, done_b;

  int  n_chk = 0;
  int  n_fail = 0;
  bit  fin_a = 0, fin_b = 0;

  always #5 clk = ~clk;

  gig_ethernet_pcs_pma_reset_seq #(
    .NUM_REQ(2), .SYNC_STAGES(A_S), .HOLD_CYCLES(A_H), .NUM_OUT(A_N), .STAGGER_CYCLES(A_G)
  ) u_dut_a (
    .clk(clk), .reset_n(rstn_a), .reset_req(req_a), .reset_out(out_a), .reset_done(done_a)
  );

  gig_ethernet_pcs_pma_reset_seq #(
    .NUM_REQ(2), .SYNC_STAGES(B_S), .HOLD_CYCLES(B_H), .NUM_OUT(B_N), .STAGGER_CYCLES(B_G)
  ) u_dut_b (
    .clk(clk), .reset_n(rstn_b), .reset_req(req_b), .reset_out(out_b), .reset_done(done_b)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Output k is released once requests have been idle 1+HOLD+k*STAGGER edges.
  function automatic logic [7:0] exp_out(input int t, input int h, input int g, input int n);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k] = (t < 1 + h + k * g);
    return r;
  endfunction

  function automatic logic [7:0] exp_done(input int t, input int h, input int g, input int n);
    return {7'd0, (t >= 1 + h + (n - 1) * g)};
  endfunction

  // ---------------- reference model + compare process ----------------
  logic [1:0] hist_a [A_S];
  logic [1:0] hist_b [B_S];
  int  t_a = 0, t_b = 0;
  bit  live_a = 0, live_b = 0;
  logic any_a, any_b;

  always @(posedge clk) begin
    if (!rstn_a) begin
      for (int i = 0; i < A_S; i++) hist_a[i] = 2'b11;
      t_a = 0; live_a = 1;
    end else if (live_a) begin
      any_a = |hist_a[A_S-1];
      for (int i = A_S - 1; i > 0; i--) hist_a[i] = hist_a[i-1];
      hist_a[0] = req_a;
      if (any_a) t_a = 0; else if (t_a < 1000000) t_a++;
    end
    if (!rstn_b) begin
      for (int i = 0; i < B_S; i++) hist_b[i] = 2'b11;
      t_b = 0; live_b = 1;
    end else if (live_b) begin
      any_b = |hist_b[B_S-1];
      for (int i = B_S - 1; i > 0; i--) hist_b[i] = hist_b[i-1];
      hist_b[0] = req_b;
      if (any_b) t_b = 0; else if (t_b < 1000000) t_b++;
    end
    #1;
    if (live_a) begin
      check("a_out",  {5'd0, out_a},  exp_out(t_a, A_H, A_G, A_N));
      check("a_done", {7'd0, done_a}, exp_done(t_a, A_H, A_G, A_N));
    end
    if (live_b) begin
      check("b_out",  {7'd0, out_b},  exp_out(t_b, B_H, B_G, B_N));
      check("b_done", {7'd0, done_b}, exp_done(t_b, B_H, B_G, B_N));
    end
  end

  // Hand-computed release timing for DUT A, edge 0 being the last edge
  // before requests are seen idle (or reset_n is seen high).
  task automatic release_chk(input string tag, input bit early);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (early && e == 3) check({tag, "_e3"}, {4'd0, done_a, out_a}, 8'b1000);
      if (early && e == 4) check({tag, "_e4"}, {4'd0, done_a, out_a}, 8'b0111);
      if (e == 20) check({tag, "_e20"}, {4'd0, done_a, out_a}, 8'b0111);
      if (e == 21) check({tag, "_e21"}, {4'd0, done_a, out_a}, 8'b0110);
      if (e == 28) check({tag, "_e28"}, {4'd0, done_a, out_a}, 8'b0110);
      if (e == 29) check({tag, "_e29"}, {4'd0, done_a, out_a}, 8'b0100);
      if (e == 36) check({tag, "_e36"}, {4'd0, done_a, out_a}, 8'b0100);
      if (e == 37) check({tag, "_e37"}, {4'd0, done_a, out_a}, 8'b1000);
    end
  endtask

  // ---------------- DUT A: directed then random ----------------
  initial begin
    int r;
    rstn_a = 1'b0; req_a = 2'b00;
    repeat (3) @(posedge clk);
    #2 rstn_a = 1'b1;
    release_chk("t1", 1'b0);

    // Single-cycle request in DONE: full restart.
    #1 req_a[1] = 1'b1;
    @(posedge clk); #2 req_a = 2'b00;
    release_chk("t2", 1'b1);

    // Pulse landing at HOLD cnt=10 pushes the release out.
    #1 req_a[1] = 1'b1;
    @(posedge clk); #2 req_a = 2'b00;
    repeat (15) @(posedge clk);
    #2 req_a[0] = 1'b1;
    @(posedge clk); #2 req_a = 2'b00;
    for (int e = 17; e <= 40; e++) begin
      @(posedge clk); #1;
      if (e == 21) check("t3_e21", {5'd0, out_a}, 8'b111);
      if (e == 36) check("t3_e36", {5'd0, out_a}, 8'b111);
      if (e == 37) check("t3_e37", {5'd0, out_a}, 8'b110);
    end

    // Request during RELEASE after bit 0 released.
    #1 req_a[0] = 1'b1;
    @(posedge clk); #2 req_a = 2'b00;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk); #1;
      if (e == 3)  check("t4_e3",  {5'd0, out_a}, 8'b110);
      if (e == 4)  check("t4_e4",  {5'd0, out_a}, 8'b111);
      if (e == 20) check("t4_e20", {5'd0, out_a}, 8'b111);
      if (e == 21) check("t4_e21", {5'd0, out_a}, 8'b110);
    end

    // reset_n low mid-RELEASE.
    #1 rstn_a = 1'b0;
    @(posedge clk); #1;
    check("t5_rst", {4'd0, done_a, out_a}, 8'b0111);
    #1 rstn_a = 1'b1;
    release_chk("t5", 1'b0);

    // Random requests and occasional block resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #($urandom_range(1, 8));
      r = $urandom_range(0, 99);
      if (r < 2) req_a = 2'($urandom_range(1, 3));
      else if (r >= 40) req_a = 2'b00;
      rstn_a = ($urandom_range(0, 399) != 0);
    end
    req_a = 2'b00; rstn_a = 1'b1;
    repeat (60) @(posedge clk);
    fin_a = 1;
  end

  // ---------------- DUT B: minimal config, async toggling ----------------
  initial begin
    int d;
    rstn_b = 1'b0; req_b = 2'b00;
    repeat (3) @(posedge clk);
    #2 rstn_b = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("t6_e3", {6'd0, done_b, out_b}, 8'b01);
    @(posedge clk); #1;
    check("t6_e4", {6'd0, done_b, out_b}, 8'b10);
    for (int c = 0; c < 1500; c++) begin
      d = $urandom_range(1, 40);
      if (((int'($time) + d) % 10) == 5) d++;
      #(d);
      req_b[$urandom_range(0, 1)] ^= 1'b1;
    end
    #3 req_b = 2'b00;
    repeat (20) @(posedge clk);
    fin_b = 1;
  end

  // ---------------- termination ----------------
  initial begin
    for (int c = 0; c < 20000 && !(fin_a && fin_b); c++) @(posedge clk);
    if (!(fin_a && fin_b)) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: stimulus finished a=%0d b=%0d, required both 1", fin_a, fin_b);
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
